pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/mips_pkg.sv | 29 ++
 rtl/add_four.sv | 18 +
 rtl/pc_fetch.sv | 85 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared widths, reset constants and IF/ID record for the MIPS core
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam int ADDR_W = 32;

   localparam logic [ADDR_W-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [31:0]       NOP_WORD_DEFAULT     = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [ADDR_W-1:0] pcplus4;
      logic [31:0]       instr;
      logic              valid;
   } if_id_t;

   // J-type destination lives in the 256 MB region of the delay-slot PC.
   function automatic logic [ADDR_W-1:0] jump_dest(input logic [ADDR_W-1:0] delay_pc,
                                                   input logic [25:0]       index);
      return {delay_pc[31:28], index, 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/add_four.sv
// ============================================================================
// add_four : PC incrementer, wraps modulo 2^ADDR_W
// Revision : 1.0
// ============================================================================
`default_nettype none

module add_four
   import mips_pkg::*;
(
   input  logic [ADDR_W-1:0] a,
   output logic [ADDR_W-1:0] y
);

   assign y = a + ADDR_W'(4);

endmodule

`default_nettype wire

// File: rtl/pc_fetch.sv
// ============================================================================
// pc_fetch : program counter, next-PC selection and IF/ID pipeline register
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_fetch
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter logic [31:0]       NOP_WORD     = NOP_WORD_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [25:0]       jump_index,
   input  logic              jr,
   input  logic [ADDR_W-1:0] jr_target,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [ADDR_W-1:0] if_id_pcplus4,
   output logic [31:0]       if_id_instr,
   output logic              if_id_valid,
   output logic              addr_err
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pcplus4;
   logic [ADDR_W-1:0] next_pc;
   logic              redirect;
   if_id_t            if_id;

   add_four u_add_four (
      .a (pc),
      .y (pcplus4)
   );

   assign redirect = jr | jump | branch_taken;

   always_comb begin
      next_pc = pcplus4;
      if (jr)
         next_pc = {jr_target[ADDR_W-1:2], 2'b00};
      else if (jump)
         next_pc = jump_dest(if_id.pcplus4, jump_index);
      else if (branch_taken)
         next_pc = branch_target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_VECTOR;
         if_id    <= '{pc: '0, pcplus4: '0, instr: NOP_WORD, valid: 1'b0};
         addr_err <= 1'b0;
      end else begin
         // A redirect must land even while the hazard unit holds the pipe.
         if (!stall || redirect)
            pc <= next_pc;

         if (flush) begin
            if_id.valid <= 1'b0;
            if_id.instr <= NOP_WORD;
         end else if (!stall) begin
            if_id <= '{pc: pc, pcplus4: pcplus4, instr: imem_rdata, valid: 1'b1};
         end

         if (jr && (jr_target[1:0] != 2'b00))
            addr_err <= 1'b1;
      end
   end

   assign imem_addr     = pc;
   assign if_id_pc      = if_id.pc;
   assign if_id_pcplus4 = if_id.pcplus4;
   assign if_id_instr   = if_id.instr;
   assign if_id_valid   = if_id.valid;

endmodule

`default_nettype wire
